// File: rtl/pipe_buf_pkg.sv
// Shared constants and width helpers for the pipe_buf elastic register slice.
package pipe_buf_pkg;

  localparam int unsigned PB_BW_DATA_DEF = 32;
  localparam int unsigned PB_DEPTH_DEF   = 2;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_buf_stage.sv
// One valid/data register stage of pipe_buf with its stage-local ready term.
module pipe_buf_stage #(
  parameter int unsigned          BW_DATA = 32,
  parameter logic [BW_DATA-1:0]   RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_ready,
  output logic               o_ready,
  output logic               o_valid,
  output logic [BW_DATA-1:0] o_data
);

  logic               v_q, v_d;
  logic [BW_DATA-1:0] d_q, d_d;

  // An empty stage always accepts, so bubbles collapse under a stalled output.
  assign o_ready = ~v_q | i_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (o_ready) begin
      v_d = i_valid;
    end
    if (o_ready && i_valid && !i_flush) begin
      d_d = i_data;
    end
    if (i_flush) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign o_valid = v_q;
  assign o_data  = d_q;

endmodule

// File: rtl/pipe_buf.sv
// Elastic pipeline buffer: DEPTH chained valid/ready stages with flush and occupancy count.
module pipe_buf
  import pipe_buf_pkg::*;
#(
  parameter int unsigned        BW_DATA = PB_BW_DATA_DEF,
  parameter int unsigned        DEPTH   = PB_DEPTH_DEF,
  parameter logic [BW_DATA-1:0] RST_VAL = '0,
  localparam int unsigned       BW_CNT  = cnt_width(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_data,
  input  logic               i_flush,
  output logic [BW_CNT-1:0]  o_count
);

  // Index 0 of each chain is the upstream side; index DEPTH is the output side.
  logic [DEPTH:0]     rdy;
  logic [DEPTH:0]     vld;
  logic [BW_DATA-1:0] dat [DEPTH+1];

  assign rdy[DEPTH] = i_ready;
  assign vld[0]     = i_valid;
  assign dat[0]     = i_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_buf_stage #(
      .BW_DATA (BW_DATA),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_flush),
      .i_valid (vld[k]),
      .i_data  (dat[k]),
      .i_ready (rdy[k+1]),
      .o_ready (rdy[k]),
      .o_valid (vld[k+1]),
      .o_data  (dat[k+1])
    );
  end

  assign o_ready = rdy[0] | i_flush;
  assign o_valid = vld[DEPTH];
  assign o_data  = dat[DEPTH];

  logic              in_fire, out_fire;
  logic [BW_CNT-1:0] cnt_q, cnt_d;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    cnt_d = cnt_q + BW_CNT'(in_fire) - BW_CNT'(out_fire);
    if (i_flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_count = cnt_q;

  a_count_matches_valids : assert property (
    @(posedge i_clk) disable iff (i_rst)
      cnt_q == BW_CNT'($countones(vld[DEPTH:1]))
  );

endmodule
